systolic_ctrl: RTL
==================

// Module: systolic_ctrl
// PURPOSE
//  Job sequencer for the 4x4 systolic_array. Buffers operand matrix A (ROWS x K) and B (K x COLS).
//  On start it does three things:
//    - clears the array;
//    - streams A rows on west lanes and B columns on north lanes with diagonal skew;
//    - waits for the pipeline to drain.
//  It then captures the array's psu_out vector and offers it on a valid/ready result port.
// PARAMETERS
//  ROWS      4   array rows = number of west lanes
//  COLS      4   array cols = number of north lanes
//  DW        8   operand width (WEST_DW = NORTH_DW)
//  PSW       16  partial-sum width per column
//  K_MAX     16  max inner dimension; buffer depth per lane
//  DRAIN_CYC 2   cycles waited after last feed beat before capture (>=1)
// PORTS
//  clk         in   1          clock, all state on rising edge
//  rst         in   1          asynchronous, active-high reset
//  op_wr_en    in   1          operand buffer write strobe
//  op_wr_sel   in   1          0 = A buffer, 1 = B buffer
//  op_wr_lane  in   2          A: row index; B: column index
//  op_wr_k     in   4          inner index k
//  op_wr_data  in   DW         operand value (unsigned)
//  cfg_k       in   5          inner dimension K for the job, legal 1..K_MAX, sampled at start
//  start       in   1          job request, single-cycle pulse
//  busy        out  1          high from accepted start until result handshake completes
//  done        out  1          1-cycle pulse on result handshake
//  err         out  1          1-cycle pulse when a start is rejected (illegal cfg_k)
//  arr_clr     out  1          drives array rst; clears PE accumulators/regs
//  west_out    out  ROWS*DW    lane i at [i*DW +: DW]; to systolic_array west_in[i]
//  north_out   out  COLS*DW    lane c at [c*DW +: DW]; to systolic_array north_in[c]
//  psu_in      in   COLS*PSW   from systolic_array psu_out
//  res_valid   out  1          result available
//  res_ready   in   1          consumer accepts result
//  res_data    out  COLS*PSW   captured psu_in
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; arr_clr=0. Operand buffers are not reset.
//  FSM states:
//   IDLE:
//    - start with 1<=cfg_k<=K_MAX -> CLEAR, latch K, busy=1.
//    - start with cfg_k=0 or cfg_k>K_MAX -> err pulse next cycle; stay IDLE.
//   CLEAR: 1 cycle, arr_clr=1, west_out/north_out=0 -> FEED with t=0.
//   FEED: runs for FL = K+ROWS+COLS-2 cycles, t = 0..FL-1. In cycle t:
//    - west lane i = A[i][t-i] if 0<=t-i<K, else 0.
//    - north lane c = B[t-c][c] if 0<=t-c<K, else 0.
//    - After t=FL-1 -> DRAIN.
//   DRAIN: DRAIN_CYC cycles, lanes 0. On the last cycle, res_data<=psu_in -> RESULT.
//   RESULT: res_valid=1 and res_data held stable until res_valid&&res_ready.
//    - On handshake, next cycle: IDLE, busy=0, done=1 for one cycle.
//  Latency from start (cycle 0) to first res_valid: 1+1+FL+DRAIN_CYC cycles.
//  Rules:
//   - Feed outputs are registered; the west_out/north_out values for cycle t appear in that cycle.
//   - start while busy is ignored (no err).
//   - op_wr_en while busy is ignored; writes only land in IDLE.
//   - Simultaneous start and op_wr_en in IDLE: the write lands and the job uses the new value.
//   - The K and t counters do not wrap; t width covers K_MAX+ROWS+COLS-2.
//   - rst mid-job aborts the job immediately: no done, res_valid=0, buffers keep their contents.
// CONFIGURATION
//  SA_CTRL_PERF_EN defined:
//   - Adds output perf_cycles [15:0]. It clears on accepted start and increments every cycle while busy.
//   - It saturates at 16'hFFFF and holds its value after done until the next start.
//   - Reset value is 0.
//  SA_CTRL_PERF_EN undefined: no port and no counter logic; all other behaviour is identical.
// TESTING
//  1) Reset mid-FEED: assert rst at t=3 -> busy=0, arr_clr=0, lanes=0 same cycle, no done.
//     Rerun the job -> correct result without reloading operands.
//  2) Identity: A=I4, B[k][c]=4k+c+1, K=4 -> res_data cols = 13,14,15,16 (row 3 of C).
//     res_valid first high exactly 2+10+2=14 cycles after start.
//  3) Skew check: K=2, A[i][k]=16i+k+1 -> west lane 2 shows 0,0,33,34,0 for t=0..4.
//     North lanes show the same pattern shifted by c.
//  4) Illegal K: cfg_k=0, then cfg_k=17 -> err pulse each time, busy stays 0, no arr_clr.
//  5) Backpressure/collision: hold res_ready=0 for 20 cycles -> res_data stable, no done.
//     Pulse start and op_wr_en mid-job -> both ignored.
//     Raise res_ready -> done 1 cycle later.
//  6) PERF (SA_CTRL_PERF_EN defined), K=4 with res_ready held high -> perf_cycles=15 at done.

Source files
------------

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - job sequencer feeding a skewed operand stream into the 4x4 systolic_array
// Optional SA_CTRL_PERF_EN adds the perf_cycles busy-cycle counter.
module systolic_ctrl #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int DW        = 8,
  parameter int PSW       = 16,
  parameter int K_MAX     = 16,
  parameter int DRAIN_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_wr_en,
  input  logic                op_wr_sel,
  input  logic [1:0]          op_wr_lane,
  input  logic [3:0]          op_wr_k,
  input  logic [DW-1:0]       op_wr_data,
  input  logic [4:0]          cfg_k,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                arr_clr,
  output logic [ROWS*DW-1:0]  west_out,
  output logic [COLS*DW-1:0]  north_out,
  input  logic [COLS*PSW-1:0] psu_in,
  output logic                res_valid,
  input  logic                res_ready,
`ifdef SA_CTRL_PERF_EN
  output logic [15:0]         perf_cycles,
`endif
  output logic [COLS*PSW-1:0] res_data
);

  localparam int TW  = $clog2(K_MAX + ROWS + COLS - 1);
  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int KIW = $clog2(K_MAX);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_RESULT} state_t;

  state_t         state, state_nxt;
  logic [TW-1:0]  t, t_nxt, t_last;
  logic [DCW-1:0] dcnt, dcnt_nxt;
  logic [4:0]     k_reg;
  logic           accept, reject, handshake, capture;
  logic [ROWS*DW-1:0] west_nxt;
  logic [COLS*DW-1:0] north_nxt;

  logic [DW-1:0] a_buf [ROWS][K_MAX];
  logic [DW-1:0] b_buf [COLS][K_MAX];

  // Operand buffers carry no reset so a reset mid-job leaves them reusable.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && op_wr_en) begin
      if (!op_wr_sel)
        a_buf[op_wr_lane][op_wr_k] <= op_wr_data;
      else
        b_buf[op_wr_lane][op_wr_k] <= op_wr_data;
    end
  end

  assign t_last = TW'(k_reg) + TW'(ROWS + COLS - 3);

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    dcnt_nxt  = dcnt;
    accept    = 1'b0;
    reject    = 1'b0;
    handshake = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (cfg_k != 5'd0 && cfg_k <= 5'(K_MAX)) begin
            accept    = 1'b1;
            state_nxt = S_CLEAR;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        state_nxt = S_FEED;
        t_nxt     = '0;
      end
      S_FEED: begin
        if (t == t_last) begin
          state_nxt = S_DRAIN;
          dcnt_nxt  = '0;
        end else begin
          t_nxt = t + TW'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt == DCW'(DRAIN_CYC - 1)) begin
          capture   = 1'b1;
          state_nxt = S_RESULT;
        end else begin
          dcnt_nxt = dcnt + DCW'(1);
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          handshake = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lane values are computed for the coming cycle so the registered outputs line up with t.
  always_comb begin
    int d;
    d         = 0;
    west_nxt  = '0;
    north_nxt = '0;
    if (state_nxt == S_FEED) begin
      for (int i = 0; i < ROWS; i++) begin
        d = int'(t_nxt) - i;
        if (d >= 0 && d < int'(k_reg))
          west_nxt[i*DW +: DW] = a_buf[i][d[KIW-1:0]];
      end
      for (int c = 0; c < COLS; c++) begin
        d = int'(t_nxt) - c;
        if (d >= 0 && d < int'(k_reg))
          north_nxt[c*DW +: DW] = b_buf[c][d[KIW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      t         <= '0;
      dcnt      <= '0;
      k_reg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      arr_clr   <= 1'b0;
      west_out  <= '0;
      north_out <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state     <= state_nxt;
      t         <= t_nxt;
      dcnt      <= dcnt_nxt;
      if (accept)
        k_reg <= cfg_k;
      busy      <= accept | (busy & ~handshake);
      done      <= handshake;
      err       <= reject;
      arr_clr   <= (state_nxt == S_CLEAR);
      west_out  <= west_nxt;
      north_out <= north_nxt;
      res_valid <= (state_nxt == S_RESULT);
      if (capture)
        res_data <= psu_in;
    end
  end

`ifdef SA_CTRL_PERF_EN
  // The start cycle itself is counted, hence the load of 1 rather than 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_cycles <= '0;
    else if (accept)
      perf_cycles <= 16'd1;
    else if (busy && perf_cycles != 16'hFFFF)
      perf_cycles <= perf_cycles + 16'd1;
  end
`endif

endmodule
